// File: rtl/tx_fc_credit_manager_pkg.sv
// Shared types for the TX arbiter / flow-control credit path.
// Holds the credit-type and result encodings plus the FC state enum.
package Tx_Arbiter_Package;

   localparam int unsigned PTLP_WIDTH   = 10;
   localparam int unsigned FC_NUM_TYPES = 3;

   typedef enum logic [1:0] {
      FC_NOP = 2'd0,
      FC_P   = 2'd1,
      FC_NP  = 2'd2,
      FC_CPL = 2'd3
   } FC_command_t;

   typedef enum logic [1:0] {
      FC_FAILED      = 2'd0,
      FC_SUCCESS_1   = 2'd1,
      FC_SUCCESS_2   = 2'd2,
      FC_SUCCESS_1_2 = 2'd3
   } FC_result_t;

   typedef enum logic [1:0] {
      FC_RESET  = 2'd0,
      FC_INIT   = 2'd1,
      FC_ACTIVE = 2'd2
   } fc_state_t;

   // One-hot select of the tracker owning a credit type; NOP selects none.
   function automatic logic [FC_NUM_TYPES-1:0] fc_type_onehot(input FC_command_t cmd);
      logic [FC_NUM_TYPES-1:0] oh;
      oh = '0;
      case (cmd)
         FC_P:    oh = 3'b001;
         FC_NP:   oh = 3'b010;
         FC_CPL:  oh = 3'b100;
         default: oh = '0;
      endcase
      return oh;
   endfunction

   function automatic FC_result_t fc_result(input logic pass1, input logic pass2);
      FC_result_t r;
      r = FC_FAILED;
      case ({pass2, pass1})
         2'b01:   r = FC_SUCCESS_1;
         2'b10:   r = FC_SUCCESS_2;
         2'b11:   r = FC_SUCCESS_1_2;
         default: r = FC_FAILED;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tx_fc_credit_manager_if.sv
// Candidate/result bundle between the TX arbiter and the credit manager.
interface Tx_FC_Interface;
   import Tx_Arbiter_Package::*;

   logic [PTLP_WIDTH-1:0] PTLP_1;
   logic [PTLP_WIDTH-1:0] PTLP_2;
   FC_command_t           Command_1;
   FC_command_t           Command_2;
   FC_result_t            Result;

   modport FC_ARBITER (input PTLP_1, PTLP_2, Command_1, Command_2, output Result);
   modport TX_ARBITER (output PTLP_1, PTLP_2, Command_1, Command_2, input Result);

endinterface

// File: rtl/tx_fc_credit_manager_tracker.sv
// Credit limit/consumed registers and the pass check for a single credit type.
// Candidate 2 is checked against the consumed count already advanced by candidate 1.
module tx_fc_type_tracker #(
   parameter int unsigned HDR_W  = 12,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              init_ld_i,
   input  logic              upd_ld_i,
   input  logic [HDR_W-1:0]  hdr_val_i,
   input  logic [DATA_W-1:0] data_val_i,
   input  logic              sel1_i,
   input  logic              sel2_i,
   input  logic [DATA_W-1:0] need1_i,
   input  logic [DATA_W-1:0] need2_i,
   output logic              pass1_c_o,
   output logic              pass2_c_o
);

   localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

   logic [HDR_W-1:0]  cl_hdr_q, cl_hdr_d, cc_hdr_q, cc_hdr_d;
   logic [DATA_W-1:0] cl_data_q, cl_data_d, cc_data_q, cc_data_d;
   logic              inf_hdr_q, inf_hdr_d, inf_data_q, inf_data_d;
   logic [HDR_W-1:0]  hdr_cons1, hdr_cons2;
   logic [DATA_W-1:0] data_cons1, data_cons2;
   logic              pass1, pass2;

   // Modular room test: the limit is still ahead of (or equal to) the new consumed count.
   function automatic logic hdr_fits(input logic [HDR_W-1:0] cl, input logic [HDR_W-1:0] cons);
      logic [HDR_W-1:0] room;
      room = cl - cons;
      return room <= HDR_HALF;
   endfunction

   function automatic logic data_fits(input logic [DATA_W-1:0] cl, input logic [DATA_W-1:0] cons);
      logic [DATA_W-1:0] room;
      room = cl - cons;
      return room <= DATA_HALF;
   endfunction

   always_comb begin
      hdr_cons1  = cc_hdr_q + HDR_W'(1);
      data_cons1 = cc_data_q + need1_i;
      pass1      = sel1_i & (inf_hdr_q | hdr_fits(cl_hdr_q, hdr_cons1))
                          & (inf_data_q | data_fits(cl_data_q, data_cons1));
      hdr_cons2  = (pass1 ? hdr_cons1 : cc_hdr_q) + HDR_W'(1);
      data_cons2 = (pass1 ? data_cons1 : cc_data_q) + need2_i;
      pass2      = sel2_i & (inf_hdr_q | hdr_fits(cl_hdr_q, hdr_cons2))
                          & (inf_data_q | data_fits(cl_data_q, data_cons2));
      pass1_c_o  = pass1;
      pass2_c_o  = pass2;
   end

   always_comb begin
      cl_hdr_d   = cl_hdr_q;
      cc_hdr_d   = cc_hdr_q;
      cl_data_d  = cl_data_q;
      cc_data_d  = cc_data_q;
      inf_hdr_d  = inf_hdr_q;
      inf_data_d = inf_data_q;

      if (!inf_hdr_q) begin
         if (pass2)      cc_hdr_d = hdr_cons2;
         else if (pass1) cc_hdr_d = hdr_cons1;
      end
      if (!inf_data_q) begin
         if (pass2)      cc_data_d = data_cons2;
         else if (pass1) cc_data_d = data_cons1;
      end

      // A zero InitFC value advertises infinite credit for that field.
      if (init_ld_i) begin
         cl_hdr_d   = hdr_val_i;
         cl_data_d  = data_val_i;
         inf_hdr_d  = (hdr_val_i == '0);
         inf_data_d = (data_val_i == '0);
      end else if (upd_ld_i) begin
         if (!inf_hdr_q)  cl_hdr_d  = hdr_val_i;
         if (!inf_data_q) cl_data_d = data_val_i;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         cl_hdr_q   <= '0;
         cc_hdr_q   <= '0;
         cl_data_q  <= '0;
         cc_data_q  <= '0;
         inf_hdr_q  <= 1'b0;
         inf_data_q <= 1'b0;
      end else begin
         cl_hdr_q   <= cl_hdr_d;
         cc_hdr_q   <= cc_hdr_d;
         cl_data_q  <= cl_data_d;
         cc_data_q  <= cc_data_d;
         inf_hdr_q  <= inf_hdr_d;
         inf_data_q <= inf_data_d;
      end
   end

endmodule

// File: rtl/tx_fc_credit_manager.sv
// Transmit flow-control credit manager: collects InitFC/UpdateFC from the DLL and
// grants up to two candidate TLPs per cycle against the P/NP/CPL credit pools.
module tx_fc_credit_manager
   import Tx_Arbiter_Package::*;
#(
   parameter int unsigned FC_HDR_WIDTH  = 12,
   parameter int unsigned FC_DATA_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     arst,
   Tx_FC_Interface.FC_ARBITER       fc_if,
   input  logic                     dll_fc_valid,
   input  logic                     dll_fc_init,
   input  FC_command_t              dll_fc_type,
   input  logic [FC_HDR_WIDTH-1:0]  dll_hdr_credits,
   input  logic [FC_DATA_WIDTH-1:0] dll_data_credits,
   output logic                     fc_ready
);

   fc_state_t                state_q, state_d;
   logic [FC_NUM_TYPES-1:0]  seen_q, seen_d;
   logic [FC_NUM_TYPES-1:0]  init_ld, upd_ld, sel1, sel2, pass1, pass2;
   logic [FC_DATA_WIDTH-1:0] need1, need2;
   logic                     active;

   assign active  = (state_q == FC_ACTIVE);
   assign need1   = FC_DATA_WIDTH'(fc_if.PTLP_1);
   assign need2   = FC_DATA_WIDTH'(fc_if.PTLP_2);
   assign init_ld = (state_q == FC_INIT && dll_fc_valid && dll_fc_init) ?
                    fc_type_onehot(dll_fc_type) : '0;
   assign upd_ld  = (active && dll_fc_valid && !dll_fc_init) ?
                    fc_type_onehot(dll_fc_type) : '0;
   assign sel1    = active ? fc_type_onehot(fc_if.Command_1) : '0;
   assign sel2    = active ? fc_type_onehot(fc_if.Command_2) : '0;

   // Link-up sequencing: ACTIVE once every credit type has seen its InitFC.
   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      unique case (state_q)
         FC_RESET: begin
            state_d = FC_INIT;
            seen_d  = '0;
         end
         FC_INIT: begin
            seen_d = seen_q | init_ld;
            if (&seen_d) state_d = FC_ACTIVE;
         end
         FC_ACTIVE: state_d = FC_ACTIVE;
         default:   state_d = FC_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= FC_RESET;
         seen_q   <= '0;
         fc_ready <= 1'b0;
      end else begin
         state_q  <= state_d;
         seen_q   <= seen_d;
         fc_ready <= (state_d == FC_ACTIVE);
      end
   end

   for (genvar k = 0; k < FC_NUM_TYPES; k++) begin : g_trk
      tx_fc_type_tracker #(
         .HDR_W  (FC_HDR_WIDTH),
         .DATA_W (FC_DATA_WIDTH)
      ) u_trk (
         .clk_i      (clk),
         .arst_i     (arst),
         .init_ld_i  (init_ld[k]),
         .upd_ld_i   (upd_ld[k]),
         .hdr_val_i  (dll_hdr_credits),
         .data_val_i (dll_data_credits),
         .sel1_i     (sel1[k]),
         .sel2_i     (sel2[k]),
         .need1_i    (need1),
         .need2_i    (need2),
         .pass1_c_o  (pass1[k]),
         .pass2_c_o  (pass2[k])
      );
   end

   // Selects are gated by ACTIVE, so any other state yields FC_FAILED.
   always_comb begin
      fc_if.Result = fc_result(|pass1, |pass2);
   end

endmodule

// File: doc/tx_fc_credit_manager.md
TX_FC_CREDIT_MANAGER -- requirements
Module: tx_fc_credit_manager

Interface
REQ-001 SHALL have parameter FC_HDR_WIDTH, default 12, header credit counter/limit width.
REQ-002 SHALL have parameter FC_DATA_WIDTH, default 16, data credit counter/limit width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 arst  in  1  reset, asynchronous, active-high.
REQ-005 PTLP_1  in  10  data credits needed by candidate TLP 1 (0 = no payload).
REQ-006 PTLP_2  in  10  data credits needed by candidate TLP 2.
REQ-007 Command_1  in  FC_command_t  credit type of candidate 1: FC_NOP, FC_P, FC_NP or FC_CPL.
REQ-008 Command_2  in  FC_command_t  credit type of candidate 2.
REQ-009 Result  out  FC_result_t  FC_FAILED, FC_SUCCESS_1, FC_SUCCESS_2 or FC_SUCCESS_1_2.
REQ-010 dll_fc_valid  in  1  DLL credit message strobe, one cycle per message.
REQ-011 dll_fc_init  in  1  1 = InitFC, 0 = UpdateFC.
REQ-012 dll_fc_type  in  FC_command_t  credit type of message (FC_NOP ignored).
REQ-013 dll_hdr_credits  in  FC_HDR_WIDTH  header credit limit value.
REQ-014 dll_data_credits  in  FC_DATA_WIDTH  data credit limit value.
REQ-015 fc_ready  out  1  high in FC_ACTIVE.

Function
REQ-016 Per type (P, NP, CPL) SHALL hold CL_hdr, CC_hdr (FC_HDR_WIDTH), CL_data, CC_data (FC_DATA_WIDTH), inf_hdr, inf_data flags.
REQ-017 State machine SHALL be FC_RESET -> FC_INIT (next clock) -> FC_ACTIVE once InitFC received for all three types; FC_ACTIVE exits only on arst.
REQ-018 InitFC in FC_INIT SHALL load CL_hdr/CL_data; a value of 0 SHALL set the corresponding inf flag; InitFC in FC_ACTIVE SHALL be ignored.
REQ-019 UpdateFC in FC_ACTIVE SHALL overwrite the non-infinite limit(s) of its type; UpdateFC in FC_INIT and updates to infinite fields SHALL be ignored.
REQ-020 Header need SHALL be 1, data need SHALL be PTLP_n zero-extended; a field passes iff inf set or ((CL - (CC + need)) mod 2^W) <= 2^(W-1).
REQ-021 Candidate passes iff Command_n != FC_NOP, state is FC_ACTIVE, and both header and data fields pass.
REQ-022 Candidate 1 SHALL be checked first; candidate 2 SHALL be checked against CC already advanced by candidate 1's need when candidate 1 passes and shares its type.
REQ-023 Result SHALL be combinational, same cycle as inputs: both pass -> FC_SUCCESS_1_2, only 1 -> FC_SUCCESS_1, only 2 -> FC_SUCCESS_2, else FC_FAILED.
REQ-024 On each clock, CC of each passing candidate's type SHALL advance by its need, modulo 2^W (wrap-around intended); both candidates of one type SHALL advance by the sum.
REQ-025 Infinite fields SHALL not advance CC.
REQ-026 DLL update and consumption in the same cycle SHALL both take effect; the check uses pre-edge CL.
REQ-027 Result SHALL be FC_FAILED whenever state is not FC_ACTIVE.

Reset
REQ-028 arst SHALL force state FC_RESET, all CL/CC to 0, all inf flags to 0, fc_ready to 0, Result to FC_FAILED, immediately and regardless of clk.
REQ-029 Reset mid-operation SHALL discard all credits; a full InitFC sequence SHALL be required again.

Structure
REQ-030 FC_command_t, FC_result_t, FC state enum and the 10-bit PTLP width constant SHALL live in Tx_Arbiter_Package.
REQ-031 Candidate/result ports SHALL connect through Tx_FC_Interface modport FC_ARBITER.
REQ-032 One sub-module tx_fc_type_tracker (CL/CC/inf registers plus pass check for one type) SHALL be instantiated three times.

Verification
REQ-033 InitFC P hdr=4 data=16, NP/CPL hdr=4 data=16; Command_1=FC_P PTLP_1=8 -> FC_SUCCESS_1, P CC_data=8, CC_hdr=1.
REQ-034 Next cycle Command_1=FC_P PTLP_1=8, Command_2=FC_P PTLP_2=1 -> FC_SUCCESS_1; P CC_data=16.
REQ-035 InitFC CPL data=0 -> Command_1=FC_CPL PTLP_1=1023 repeated 10 cycles -> FC_SUCCESS_1 every cycle, CC_data unchanged.
REQ-036 FC_DATA_WIDTH=8: CL_data=0x02 via UpdateFC, CC_data=0xFE -> PTLP_1=4 -> FC_SUCCESS_1, CC_data=0x02; PTLP_1=1 -> FC_FAILED.
REQ-037 Before all InitFC received, any command -> FC_FAILED, fc_ready=0; arst asserted in FC_ACTIVE -> fc_ready=0 and Result=FC_FAILED without a clock edge.
